// File: rtl/dm_responder.sv
// dm_responder: word-organised data memory behind a request/ready handshake.
// A request (CE with WE or RE) is accepted in IDLE and its fields are latched.
// It then waits WAIT_CYCLES cycles and completes with a one-cycle READY pulse.
// A write is committed on the edge that enters RESP. Addresses past
// DEPTH_WORDS complete with ERR=1 and perform no write.
// Optional macro DM_WRITE_LOG_EN prints one simulation line per committed write.
module dm_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] ADDR,
    input  logic        CE,
    input  logic        WE,
    input  logic        RE,
    input  logic [3:0]  BE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        READY,
    output logic        ERR
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] dout_q;

    // Request fields captured at acceptance
    logic [29:0] waddr_q;
    logic        we_q;
    logic        re_q;
    logic [3:0]  be_q;
    logic [31:0] din_q;
    logic [31:0] pc_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Fields of the transaction that completes on this edge
    logic          accept;
    logic          commit;
    logic [29:0]   t_waddr;
    logic          t_we;
    logic          t_re;
    logic [3:0]    t_be;
    logic [31:0]   t_din;
    logic [31:0]   t_pc;
    logic          in_range;
    logic [AW-1:0] t_idx;
    logic [31:0]   rd_word;
    logic [31:0]   merged;

    assign accept = (state_q == S_IDLE) && CE && (WE || RE);
    // With no wait states the access completes on the accepting edge itself,
    // so the live inputs are used; otherwise the latched copy is used.
    assign commit = (accept && ZERO_WAIT) || ((state_q == S_WAIT) && (cnt_q == 4'd0));

    // Select live or latched request fields for the completing transaction
    always_comb begin
        t_waddr = waddr_q;
        t_we    = we_q;
        t_re    = re_q;
        t_be    = be_q;
        t_din   = din_q;
        t_pc    = pc_q;
        if (state_q == S_IDLE) begin
            t_waddr = ADDR[31:2];
            t_we    = WE;
            t_re    = RE;
            t_be    = BE;
            t_din   = DIN;
            t_pc    = PC;
        end
    end

    assign in_range = ({2'b00, t_waddr} < 32'(DEPTH_WORDS));
    assign t_idx    = t_waddr[AW-1:0];
    assign rd_word  = mem_q[t_idx];

    // Byte-lane merge of write data into the stored word
    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (t_be[b]) begin
                merged[8*b +: 8] = t_din[8*b +: 8];
            end
        end
    end

    // Capture request fields on acceptance so the initiator may move on
    always_ff @(posedge clk) begin
        if (accept) begin
            waddr_q <= ADDR[31:2];
            we_q    <= WE;
            re_q    <= RE;
            be_q    <= BE;
            din_q   <= DIN;
            pc_q    <= PC;
        end
    end

    // Handshake FSM with registered READY/ERR/DOUT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (ZERO_WAIT) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (commit) begin
                ready_q <= 1'b1;
                err_q   <= !in_range;
                // Read data is the pre-write word, so WE+RE returns the old value
                dout_q  <= (in_range && t_re) ? rd_word : 32'd0;
            end
        end
    end

    // Storage: cleared on every edge while reset is held, written on commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (commit && t_we && in_range) begin
            mem_q[t_idx] <= merged;
`ifdef DM_WRITE_LOG_EN
            $display("%0t@%08h: *%08h <= %08h", $time, t_pc, {t_waddr, 2'b00}, merged);
`endif
        end
    end

`ifndef DM_WRITE_LOG_EN
    logic unused_pc;
    assign unused_pc = ^t_pc;
`endif
    logic unused_addr;
    assign unused_addr = ^ADDR[1:0];

    assign READY = ready_q;
    assign ERR   = err_q;
    assign DOUT  = dout_q;

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096: number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states inserted before each response, legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port PC, input, 32 bits: PC of the instruction issuing the access, used only for the write log.
REQ-006 SHALL have port ADDR, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-007 SHALL have port CE, input, 1 bit: chip enable; a request exists only when CE=1.
REQ-008 SHALL have port WE, input, 1 bit: write request.
REQ-009 SHALL have port RE, input, 1 bit: read request.
REQ-010 SHALL have port BE, input, 4 bits: byte enables; BE[i] selects DIN[8i+7:8i].
REQ-011 SHALL have port DIN, input, 32 bits: write data.
REQ-012 SHALL have port DOUT, output, 32 bits: read data, valid only while READY=1.
REQ-013 SHALL have port READY, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port ERR, output, 1 bit: out-of-range flag, valid only while READY=1.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 In IDLE, CE=1 with WE=1 or RE=1 at a rising edge SHALL accept the request; ADDR, WE, RE, BE, DIN and PC SHALL be latched there, so the initiator may change them afterwards.
REQ-017 On acceptance SHALL go to WAIT with a counter loaded to WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES=0.
REQ-018 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP, giving READY exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 In RESP, READY SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; requests presented in WAIT or RESP SHALL be ignored, not queued.
REQ-020 A write SHALL be committed at the edge entering RESP: each byte with BE[i]=1 replaced from DIN; BE=0000 SHALL leave memory unchanged but still complete.
REQ-021 A read SHALL drive DOUT with the full word at the latched word address during RESP; BE SHALL not mask reads.
REQ-022 WE=1 and RE=1 together SHALL be a write, with DOUT returning the pre-write word.
REQ-023 When ADDR[31:2] >= DEPTH_WORDS, the block SHALL assert ERR=1 with READY, perform no write, and drive DOUT=0.
REQ-024 Outside RESP, DOUT SHALL be 0 and ERR SHALL be 0.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, READY=0, ERR=0, DOUT=0 and counter=0, without waiting for clk.
REQ-026 Memory SHALL be zeroed at every rising edge of clk while reset=0; reset SHALL be held for at least one clk edge.
REQ-027 Reset during WAIT SHALL discard the pending access: no write is committed and no READY is issued.
REQ-028 After reset returns to 1, the first request SHALL be accepted at the next edge in IDLE.

Configuration
REQ-029 Macro DM_WRITE_LOG_EN, when defined, SHALL make every committed write print one simulation line "<time>@<PC hex8>: *<word-aligned addr hex8> <= <merged word hex8>", including BE=0000 writes; out-of-range writes SHALL not print.
REQ-030 Without DM_WRITE_LOG_EN, the block SHALL produce no simulation output, and its synthesized behaviour SHALL be identical.

Verification
REQ-031 Write/read: write DIN=0x12345678, BE=1111 to ADDR=0x00000010, then read it (WAIT_CYCLES=2) -> READY on the 3rd cycle after each accept, and the read DOUT=0x12345678.
REQ-032 Byte merge: word 0x00000010 holds 0x12345678; write DIN=0xAABBCCDD, BE=0101 -> a read returns 0x12BB56DD.
REQ-033 Zero wait: with WAIT_CYCLES=0, a read request at edge N -> READY=1 during the cycle after edge N only; a request held high during RESP is ignored, and the next accept occurs at edge N+2.
REQ-034 Out of range: with DEPTH_WORDS=4096, write to ADDR=0x00004000 -> READY=1, ERR=1, DOUT=0; word 0 is unchanged; no log line is printed.
REQ-035 Reset mid-op: with WAIT_CYCLES=3, write 0xFFFFFFFF to 0x4 and assert reset=0 one cycle after accept -> READY stays 0, and a later read of 0x4 returns 0x00000000.
REQ-036 Log: with DM_WRITE_LOG_EN, PC=0x00003000, write 0x0000BEEF to ADDR=0x0000000A, BE=0011 -> one line ending "@00003000: *00000008 <= 0000beef".
